// File: rtl/ehl_ahb_simple_master.sv
// Single-transfer AHB-Lite master: a command is accepted into an address-phase
// stage, moves to a data-phase stage, and produces one in-order response.
module ehl_ahb_simple_master #(
    parameter logic [3:0] HPROT_VAL = 4'h3
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_abort,
    output logic        busy,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic          ap_valid_q, ap_valid_d;
    logic          ap_write_q, ap_write_d;
    logic [AW-1:0] ap_addr_q,  ap_addr_d;
    logic [2:0]    ap_size_q,  ap_size_d;
    logic [DW-1:0] ap_wdata_q, ap_wdata_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_write_q, dp_write_d;
    logic [DW-1:0] dp_wdata_q, dp_wdata_d;
    logic          err_st_q,   err_st_d;
    logic          abort_q,    abort_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q,   rsp_err_d;
    logic          rsp_abort_q, rsp_abort_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic          accept;
    logic          unused_hresp;

    assign unused_hresp = hresp[1];

    assign cmd_ready = hready & ~err_st_q;
    assign accept    = cmd_valid & cmd_ready;

    assign haddr     = ap_addr_q;
    assign hwrite    = ap_write_q;
    assign hsize     = ap_size_q;
    assign htrans    = ap_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwdata    = dp_wdata_q;
    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_abort = rsp_abort_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = ap_valid_q | dp_valid_q | abort_q;

    // Pipeline advance, error cancellation and response generation
    always_comb begin
        ap_valid_d  = ap_valid_q;
        ap_write_d  = ap_write_q;
        ap_addr_d   = ap_addr_q;
        ap_size_d   = ap_size_q;
        ap_wdata_d  = ap_wdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        dp_wdata_d  = dp_wdata_q;
        err_st_d    = err_st_q;
        abort_d     = abort_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_abort_d = 1'b0;
        rsp_rdata_d = '0;

        if (hready) begin
            dp_valid_d = ap_valid_q;
            if (ap_valid_q) begin
                dp_write_d = ap_write_q;
                if (ap_write_q) begin
                    dp_wdata_d = ap_wdata_q;
                end
            end
            ap_valid_d = accept;
            if (accept) begin
                ap_write_d = cmd_write;
                ap_addr_d  = cmd_addr;
                ap_size_d  = cmd_size;
                ap_wdata_d = cmd_wdata;
            end
            err_st_d = 1'b0;
        end else if (dp_valid_q && hresp[0]) begin
            // First ERROR cycle: cancel the queued address phase
            err_st_d   = 1'b1;
            ap_valid_d = 1'b0;
            if (ap_valid_q) begin
                abort_d = 1'b1;
            end
        end

        if (dp_valid_q && hready) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = hresp[0];
            rsp_rdata_d = dp_write_q ? '0 : hrdata;
        end else if (abort_q && !err_st_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_abort_d = 1'b1;
            abort_d     = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ap_valid_q  <= 1'b0;
            ap_write_q  <= 1'b0;
            ap_addr_q   <= '0;
            ap_size_q   <= '0;
            ap_wdata_q  <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            dp_wdata_q  <= '0;
            err_st_q    <= 1'b0;
            abort_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_abort_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ap_valid_q  <= ap_valid_d;
            ap_write_q  <= ap_write_d;
            ap_addr_q   <= ap_addr_d;
            ap_size_q   <= ap_size_d;
            ap_wdata_q  <= ap_wdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            dp_wdata_q  <= dp_wdata_d;
            err_st_q    <= err_st_d;
            abort_q     <= abort_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_abort_q <= rsp_abort_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_ehl_ahb_simple_master.sv
// Directed bench for ehl_ahb_simple_master: per-cycle vector table plus
// hand sequences for idle-after-reset and reset during a write wait state.
module tb_ehl_ahb_simple_master;

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_abort;
    logic        busy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int errors = 0;
    int checks = 0;

    ehl_ahb_simple_master #(.HPROT_VAL(4'h3)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_abort(rsp_abort), .busy(busy),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        cv;
        logic        cw;
        logic [31:0] ca;
        logic [2:0]  cs;
        logic [31:0] cd;
        logic        hr;
        logic [1:0]  hp;
        logic [31:0] hd;
        logic [1:0]  x_tr;
        logic        x_busy;
        logic        x_rv;
        logic        x_re;
        logic        x_ra;
        logic [31:0] x_rd;
        logic        x_crdy;
        logic        k_addr;
        logic [31:0] x_addr;
        logic        x_wr;
        logic [2:0]  x_sz;
        logic        k_wd;
        logic [31:0] x_wd;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    function automatic vec_t mk(
        input logic cv, input logic cw, input logic [31:0] ca, input logic [2:0] cs,
        input logic [31:0] cd, input logic hr, input logic [1:0] hp, input logic [31:0] hd,
        input logic [1:0] x_tr, input logic x_busy, input logic x_rv, input logic x_re,
        input logic x_ra, input logic [31:0] x_rd, input logic x_crdy,
        input logic k_addr, input logic [31:0] x_addr, input logic x_wr, input logic [2:0] x_sz,
        input logic k_wd, input logic [31:0] x_wd);
        vec_t v;
        v.cv = cv; v.cw = cw; v.ca = ca; v.cs = cs; v.cd = cd;
        v.hr = hr; v.hp = hp; v.hd = hd;
        v.x_tr = x_tr; v.x_busy = x_busy; v.x_rv = x_rv; v.x_re = x_re; v.x_ra = x_ra;
        v.x_rd = x_rd; v.x_crdy = x_crdy;
        v.k_addr = k_addr; v.x_addr = x_addr; v.x_wr = x_wr; v.x_sz = x_sz;
        v.k_wd = k_wd; v.x_wd = x_wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        hresp = 2'b00; hrdata = '0;
    endtask

    initial begin
        // Write 0x1000 zero-wait
        vt[0]  = mk(1,1,32'h1000,3'd2,32'hA5A5A5A5, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[1]  = mk(0,0,0,0,0, 1,2'b00,0, 2'd2,1,0,0,0,0,1, 1,32'h1000,1,3'd2, 0,0);
        vt[2]  = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,1,0,0,0,0,1, 0,0,0,0, 1,32'hA5A5A5A5);
        vt[3]  = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,1,0,0,0,1, 0,0,0,0, 0,0);
        vt[4]  = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        // Read 0x2000 with three wait states
        vt[5]  = mk(1,0,32'h2000,3'd1,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[6]  = mk(0,0,0,0,0, 1,2'b00,0, 2'd2,1,0,0,0,0,1, 1,32'h2000,0,3'd1, 0,0);
        vt[7]  = mk(0,0,0,0,0, 0,2'b00,0, 2'd0,1,0,0,0,0,0, 1,32'h2000,0,3'd1, 0,0);
        vt[8]  = mk(0,0,0,0,0, 0,2'b00,0, 2'd0,1,0,0,0,0,0, 1,32'h2000,0,3'd1, 0,0);
        vt[9]  = mk(0,0,0,0,0, 0,2'b00,0, 2'd0,1,0,0,0,0,0, 1,32'h2000,0,3'd1, 0,0);
        vt[10] = mk(0,0,0,0,0, 1,2'b00,32'hDE000002, 2'd0,1,0,0,0,0,1, 1,32'h2000,0,3'd1, 0,0);
        vt[11] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,1,0,0,32'hDE000002,1, 0,0,0,0, 0,0);
        // Back-to-back reads 0x10, 0x14
        vt[12] = mk(1,0,32'h10,3'd2,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[13] = mk(1,0,32'h14,3'd2,0, 1,2'b00,0, 2'd2,1,0,0,0,0,1, 1,32'h10,0,3'd2, 0,0);
        vt[14] = mk(0,0,0,0,0, 1,2'b00,32'hAAAA0010, 2'd2,1,0,0,0,0,1, 1,32'h14,0,3'd2, 0,0);
        vt[15] = mk(0,0,0,0,0, 1,2'b00,32'hBBBB0014, 2'd0,1,1,0,0,32'hAAAA0010,1, 0,0,0,0, 0,0);
        vt[16] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,1,0,0,32'hBBBB0014,1, 0,0,0,0, 0,0);
        vt[17] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        // Read A errors while read B sits in address phase; C offered but refused
        vt[18] = mk(1,0,32'h100,3'd2,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[19] = mk(1,0,32'h104,3'd2,0, 1,2'b00,0, 2'd2,1,0,0,0,0,1, 1,32'h100,0,3'd2, 0,0);
        vt[20] = mk(0,0,0,0,0, 0,2'b01,0, 2'd2,1,0,0,0,0,0, 1,32'h104,0,3'd2, 0,0);
        vt[21] = mk(1,0,32'h200,3'd2,0, 1,2'b01,32'h0BAD0BAD, 2'd0,1,0,0,0,0,0, 0,0,0,0, 0,0);
        vt[22] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,1,1,1,0,32'h0BAD0BAD,1, 0,0,0,0, 0,0);
        vt[23] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,1,1,1,0,1, 0,0,0,0, 0,0);
        // hresp with no data phase is ignored
        vt[24] = mk(0,0,0,0,0, 0,2'b01,0, 2'd0,0,0,0,0,0,0, 0,0,0,0, 0,0);
        vt[25] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        // hresp[1] alone does not flag an error
        vt[26] = mk(1,0,32'h300,3'd2,0, 1,2'b00,0, 2'd0,0,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[27] = mk(0,0,0,0,0, 1,2'b00,0, 2'd2,1,0,0,0,0,1, 1,32'h300,0,3'd2, 0,0);
        vt[28] = mk(0,0,0,0,0, 1,2'b10,32'h00000300, 2'd0,1,0,0,0,0,1, 0,0,0,0, 0,0);
        vt[29] = mk(0,0,0,0,0, 1,2'b00,0, 2'd0,0,1,0,0,32'h00000300,1, 0,0,0,0, 0,0);

        hresetn = 1'b0;
        hready  = 1'b1;
        drive_idle();
        #12;
        check("rst htrans", 32'(htrans), 32'd0);
        check("rst haddr", haddr, 32'd0);
        check("rst hwdata", hwdata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("hburst", 32'(hburst), 32'd0);
        check("hprot", 32'(hprot), 32'h3);
        check("hmastlock", 32'(hmastlock), 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;

        // Idle for 10 cycles with toggling hready
        for (int i = 0; i < 10; i++) begin
            hready = (i % 3) != 0;
            @(negedge hclk);
            check($sformatf("idle%0d htrans", i), 32'(htrans), 32'd0);
            check($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
            check($sformatf("idle%0d cmd_ready", i), 32'(cmd_ready), 32'(hready));
            @(posedge hclk); #1;
        end

        for (int i = 0; i < NV; i++) begin
            cmd_valid = vt[i].cv; cmd_write = vt[i].cw; cmd_addr = vt[i].ca;
            cmd_size = vt[i].cs; cmd_wdata = vt[i].cd;
            hready = vt[i].hr; hresp = vt[i].hp; hrdata = vt[i].hd;
            @(negedge hclk);
            check($sformatf("v%0d htrans", i), 32'(htrans), 32'(vt[i].x_tr));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vt[i].x_busy));
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vt[i].x_rv));
            check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vt[i].x_re));
            check($sformatf("v%0d rsp_abort", i), 32'(rsp_abort), 32'(vt[i].x_ra));
            check($sformatf("v%0d rsp_rdata", i), rsp_rdata, vt[i].x_rd);
            check($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(vt[i].x_crdy));
            if (vt[i].k_addr) begin
                check($sformatf("v%0d haddr", i), haddr, vt[i].x_addr);
                check($sformatf("v%0d hwrite", i), 32'(hwrite), 32'(vt[i].x_wr));
                check($sformatf("v%0d hsize", i), 32'(hsize), 32'(vt[i].x_sz));
            end
            if (vt[i].k_wd) begin
                check($sformatf("v%0d hwdata", i), hwdata, vt[i].x_wd);
            end
            @(posedge hclk); #1;
        end

        // Reset asserted during a write wait state
        drive_idle();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000; cmd_size = 3'd2;
        cmd_wdata = 32'h12345678; hready = 1'b1;
        @(posedge hclk); #1;
        drive_idle();
        @(posedge hclk); #1;
        hready = 1'b0;
        @(negedge hclk);
        check("wait1 hwdata", hwdata, 32'h12345678);
        check("wait1 busy", 32'(busy), 32'd1);
        @(posedge hclk); #1;
        @(negedge hclk);
        check("wait2 hwdata", hwdata, 32'h12345678);
        #1;
        hresetn = 1'b0;
        #1;
        check("arst htrans", 32'(htrans), 32'd0);
        check("arst haddr", haddr, 32'd0);
        check("arst hwrite", 32'(hwrite), 32'd0);
        check("arst hsize", 32'(hsize), 32'd0);
        check("arst hwdata", hwdata, 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst rsp_rdata", rsp_rdata, 32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        hready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge hclk);
            check($sformatf("post%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("post%0d busy", i), 32'(busy), 32'd0);
            @(posedge hclk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ehl_ahb_simple_master.md
EHL_AHB_SIMPLE_MASTER -- requirements
Module: ehl_ahb_simple_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'h3, constant value driven on hprot.
REQ-002 SHALL have port hclk, input, 1, clock; all state changes on posedge hclk.
REQ-003 SHALL have port hresetn, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid, input, 1, and cmd_ready, output, 1: command request and accept.
REQ-005 SHALL have ports cmd_write, input, 1; cmd_addr, input, 32; cmd_size, input, 3; cmd_wdata, input, 32: command fields.
REQ-006 SHALL have ports rsp_valid, output, 1; rsp_rdata, output, 32; rsp_err, output, 1; rsp_abort, output, 1: completion report.
REQ-007 SHALL have port busy, output, 1, high while any transfer is in address or data phase.
REQ-008 SHALL have ports haddr, output, 32; htrans, output, 2; hwrite, output, 1; hsize, output, 3; hburst, output, 3; hprot, output, 4; hmastlock, output, 1; hwdata, output, 32: AHB-Lite master outputs.
REQ-009 SHALL have ports hready, input, 1; hresp, input, 2; hrdata, input, 32: AHB-Lite slave response.

Function
REQ-010 SHALL issue single transfers only: htrans NONSEQ (2'b10) or IDLE (2'b00), hburst 3'b000, hmastlock 0, hprot HPROT_VAL; no alignment check.
REQ-011 SHALL hold two stages: address-phase register (AP) and data-phase register (DP), each with a valid bit.
REQ-012 SHALL drive cmd_ready = hready AND NOT err_st, combinationally.
REQ-013 SHALL, on a posedge with hready=1: move AP into DP (DP invalid if AP invalid), load AP from the command if cmd_valid&cmd_ready, else invalidate AP.
REQ-014 SHALL hold AP and DP unchanged on a posedge with hready=0, except as REQ-017 requires.
REQ-015 SHALL drive haddr/hwrite/hsize from AP, htrans=NONSEQ when AP valid, else IDLE; haddr/hwrite/hsize retain last values when AP invalid.
REQ-016 SHALL drive hwdata from the DP write data when DP holds a write; hwdata stable throughout wait states.
REQ-017 SHALL, on a posedge with DP valid, hready=0, hresp[0]=1 (first ERROR cycle): set err_st, clear AP valid (htrans IDLE next cycle), record cancelled AP command as abort-pending if AP was valid.
REQ-018 SHALL clear err_st on the next posedge with hready=1.
REQ-019 SHALL, on a posedge with DP valid and hready=1, assert rsp_valid for exactly the following cycle with rsp_err=hresp[0], rsp_abort=0, rsp_rdata=hrdata for reads, 32'h0 for writes.
REQ-020 SHALL report an abort-pending command one cycle after the errored response: rsp_valid=1, rsp_err=1, rsp_abort=1, rsp_rdata=0; no other command accepted in between.
REQ-021 SHALL keep responses in command-acceptance order; at most one rsp_valid per cycle.
REQ-022 SHALL drive busy = AP valid OR DP valid OR abort-pending.
REQ-023 SHALL ignore hresp when DP invalid; hresp[1] ignored always.
REQ-024 SHALL give zero-wait latency: accept edge E0, address phase cycle after E0, data phase cycle after E1, rsp_valid cycle after E2.

Reset
REQ-025 SHALL on hresetn low immediately set htrans=0, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_err=0, rsp_abort=0, rsp_rdata=0, busy=0, AP/DP/err_st/abort-pending cleared.
REQ-026 SHALL abandon any in-flight transfer on reset without issuing a response.

Verification
REQ-027 Write 0x0000_1000, data 0xA5A5A5A5, zero-wait slave -> htrans=2 one cycle after accept, hwdata=0xA5A5A5A5 next cycle, rsp_valid with err=0 following cycle.
REQ-028 Read 0x0000_2000, slave 3 wait states, hrdata=0xDE000002 -> haddr held, htrans IDLE during waits, rsp_rdata=0xDE000002, err=0 one cycle after hready returns.
REQ-029 Back-to-back reads 0x10, 0x14 zero-wait -> NONSEQ in two consecutive cycles, two consecutive rsp_valid in order.
REQ-030 Read A ERROR (hready 0/hresp 1 then 1/1) with read B in address phase -> htrans IDLE in second error cycle, rsp A err=1 abort=0, then rsp B err=1 abort=1; B never in data phase.
REQ-031 hresetn low during wait state of a write -> all outputs at reset values same cycle, no rsp_valid after release.
REQ-032 cmd_valid=0 for 10 cycles after reset -> htrans=0, busy=0, cmd_ready follows hready.
